// File: rtl/aclk_keypad_scanner.sv
// Scans a 4x3 matrix keypad, debounces whole-scan results and drives the
// alarm-clock controller key bus plus the '*' (alarm) and '#' (time) buttons.
module aclk_keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int NOKEY    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       alarm_button,
    output logic       time_button,
    output logic       key_strobe
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    localparam logic [SW-1:0] STABLE_ONE = SW'(1);
    localparam logic [3:0]    NOKEY_CODE = 4'(NOKEY);

    // Internal candidate codes: 0-9 digits, plus star/hash/none kept apart
    // from NOKEY so they never alias a digit or each other.
    localparam logic [3:0] CAND_STAR = 4'd11;
    localparam logic [3:0] CAND_HASH = 4'd12;
    localparam logic [3:0] CAND_NONE = 4'd15;

    typedef enum logic [1:0] {
        DWELL,
        SAMPLE,
        EVAL,
        COMMIT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      col_meta;
    logic [2:0]      col_sync;
    logic [1:0]      row_idx;
    logic [DW-1:0]   dwell_cnt;
    logic [11:0]     accum;
    logic [3:0]      cand;
    logic [3:0]      prev_cand;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_next;
    logic [3:0]      scan_cand;
    logic [3:0]      ones;
    logic [3:0]      hit_idx;

    assign row_n = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DWELL;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DWELL:   if (dwell_cnt == DWELL_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = (row_idx == 2'd3) ? EVAL : DWELL;
            EVAL:    next_state = COMMIT;
            COMMIT:  next_state = DWELL;
            default: next_state = DWELL;
        endcase
    end

    // Accumulator bit index is row*3+col; exactly one set bit names the key.
    always_comb begin
        ones    = 4'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (accum[i]) begin
                ones    = ones + 4'd1;
                hit_idx = 4'(i);
            end
        end
        scan_cand = CAND_NONE;
        if (ones == 4'd1) begin
            case (hit_idx)
                4'd9:    scan_cand = CAND_STAR;
                4'd10:   scan_cand = 4'd0;
                4'd11:   scan_cand = CAND_HASH;
                default: scan_cand = hit_idx + 4'd1;
            endcase
        end
    end

    always_comb begin
        stable_next = STABLE_ONE;
        if (cand == prev_cand) begin
            stable_next = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + STABLE_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx      <= 2'd0;
            dwell_cnt    <= '0;
            accum        <= '0;
            cand         <= CAND_NONE;
            prev_cand    <= CAND_NONE;
            stable_cnt   <= '0;
            key          <= NOKEY_CODE;
            alarm_button <= 1'b0;
            time_button  <= 1'b0;
            key_strobe   <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                DWELL: begin
                    if (dwell_cnt != DWELL_LAST) dwell_cnt <= dwell_cnt + 1'b1;
                end
                SAMPLE: begin
                    dwell_cnt <= '0;
                    case (row_idx)
                        2'd0:    accum[2:0]  <= ~col_sync;
                        2'd1:    accum[5:3]  <= ~col_sync;
                        2'd2:    accum[8:6]  <= ~col_sync;
                        default: accum[11:9] <= ~col_sync;
                    endcase
                    if (row_idx != 2'd3) row_idx <= row_idx + 2'd1;
                end
                EVAL: begin
                    cand <= scan_cand;
                end
                COMMIT: begin
                    prev_cand  <= cand;
                    stable_cnt <= stable_next;
                    row_idx    <= 2'd0;
                    accum      <= '0;
                    if (stable_next == STABLE_MAX) begin
                        case (cand)
                            CAND_STAR: begin
                                key          <= NOKEY_CODE;
                                alarm_button <= 1'b1;
                                time_button  <= 1'b0;
                            end
                            CAND_HASH: begin
                                key          <= NOKEY_CODE;
                                alarm_button <= 1'b0;
                                time_button  <= 1'b1;
                            end
                            CAND_NONE: begin
                                key          <= NOKEY_CODE;
                                alarm_button <= 1'b0;
                                time_button  <= 1'b0;
                            end
                            default: begin
                                key          <= cand;
                                alarm_button <= 1'b0;
                                time_button  <= 1'b0;
                                key_strobe   <= (cand != key);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Directed bench for aclk_keypad_scanner: keypad model driven from row_n,
// scan boundaries located through row_n, hand-computed expectations.
module tb_aclk_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       key_strobe;

    logic [11:0] pressed;
    int          checks;
    int          passes;
    int          strobe_count;
    int          exp_strobes;

    aclk_keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE(3),
        .NOKEY(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .col_n(col_n),
        .row_n(row_n),
        .key(key),
        .alarm_button(alarm_button),
        .time_button(time_button),
        .key_strobe(key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key bit index is row*3+col; a column reads low only while its row is driven.
    always_comb begin
        logic [2:0] cols;
        cols = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) cols = cols | pressed[r*3 +: 3];
        end
        col_n = ~cols;
    end

    always @(posedge clk) begin
        if (key_strobe) strobe_count <= strobe_count + 1;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [11:0] mask);
        pressed = mask;
    endtask

    // Each scan ends when row_n goes from the last row back to row 0.
    task automatic wait_scans(input int n);
        for (int s = 0; s < n; s++) begin
            int cyc = 0;
            while (row_n != 4'b0111 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            while (row_n != 4'b1110 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 200) begin
                checkOutput("scan_timeout", cyc, 0);
                return;
            end
        end
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        strobe_count = 0;
        exp_strobes  = 0;
        pressed      = 12'h000;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_row_n", int'(row_n), 14);
        checkOutput("reset_key", int'(key), 10);
        checkOutput("reset_alarm", int'(alarm_button), 0);
        checkOutput("reset_time", int'(time_button), 0);
        checkOutput("reset_strobe", int'(key_strobe), 0);
        reset = 1'b0;
        wait_scans(3);

        // Digit '5' held then released
        applyStimulus(12'h010);
        wait_scans(2);
        checkOutput("k5_pre", int'(key), 10);
        wait_scans(1);
        checkOutput("k5_commit", int'(key), 5);
        checkOutput("k5_strobe_now", int'(key_strobe), 1);
        exp_strobes++;
        wait_scans(3);
        checkOutput("k5_held", int'(key), 5);
        checkOutput("k5_strobes", strobe_count, exp_strobes);
        applyStimulus(12'h000);
        wait_scans(2);
        checkOutput("k5_rel_hold", int'(key), 5);
        wait_scans(1);
        checkOutput("k5_released", int'(key), 10);
        checkOutput("k5_rel_strobe", int'(key_strobe), 0);

        // '*' on alarm_button
        applyStimulus(12'h200);
        wait_scans(2);
        checkOutput("star_pre", int'(alarm_button), 0);
        wait_scans(1);
        checkOutput("star_alarm", int'(alarm_button), 1);
        checkOutput("star_key", int'(key), 10);
        checkOutput("star_time", int'(time_button), 0);
        checkOutput("star_strobe", int'(key_strobe), 0);
        applyStimulus(12'h000);
        wait_scans(3);
        checkOutput("star_rel", int'(alarm_button), 0);

        // '#' on time_button
        applyStimulus(12'h800);
        wait_scans(2);
        checkOutput("hash_pre", int'(time_button), 0);
        wait_scans(1);
        checkOutput("hash_time", int'(time_button), 1);
        checkOutput("hash_alarm", int'(alarm_button), 0);
        checkOutput("hash_key", int'(key), 10);
        applyStimulus(12'h000);
        wait_scans(3);
        checkOutput("hash_rel", int'(time_button), 0);
        checkOutput("buttons_strobes", strobe_count, exp_strobes);

        // Bouncing '8' on alternate scans, then held
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 12'h080 : 12'h000);
            wait_scans(1);
            checkOutput("bounce_key", int'(key), 10);
        end
        applyStimulus(12'h080);
        wait_scans(2);
        checkOutput("k8_pre", int'(key), 10);
        wait_scans(1);
        checkOutput("k8_commit", int'(key), 8);
        exp_strobes++;
        applyStimulus(12'h000);
        wait_scans(3);
        checkOutput("k8_rel", int'(key), 10);

        // '1' and '9' together are rejected; '1' alone commits
        applyStimulus(12'h101);
        for (int i = 0; i < 4; i++) begin
            wait_scans(1);
            checkOutput("multi_key", int'(key), 10);
        end
        applyStimulus(12'h001);
        wait_scans(2);
        checkOutput("k1_pre", int'(key), 10);
        wait_scans(1);
        checkOutput("k1_commit", int'(key), 1);
        exp_strobes++;
        applyStimulus(12'h000);
        wait_scans(3);
        checkOutput("k1_rel", int'(key), 10);
        checkOutput("multi_strobes", strobe_count, exp_strobes);

        // Roll-over '2' -> '0' without release
        applyStimulus(12'h002);
        wait_scans(3);
        checkOutput("k2_commit", int'(key), 2);
        exp_strobes++;
        applyStimulus(12'h400);
        wait_scans(2);
        checkOutput("roll_hold", int'(key), 2);
        wait_scans(1);
        checkOutput("roll_commit", int'(key), 0);
        checkOutput("roll_strobe_now", int'(key_strobe), 1);
        exp_strobes++;
        wait_scans(1);
        checkOutput("roll_strobes", strobe_count, exp_strobes);

        // Reset in the middle of a scan while '0' is held
        repeat (7) @(negedge clk);
        checkOutput("mid_scan_row", int'(row_n), 13);
        reset = 1'b1;
        #1;
        checkOutput("midrst_row_n", int'(row_n), 14);
        checkOutput("midrst_key", int'(key), 10);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_scans(2);
        checkOutput("post_rst_pre", int'(key), 10);
        wait_scans(1);
        checkOutput("post_rst_key", int'(key), 0);
        exp_strobes++;
        wait_scans(1);
        checkOutput("final_strobes", strobe_count, exp_strobes);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
